// File: rtl/exp_unpack_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : exp_unpack_sequencer (with shared sub-unit exponent)
//  Purpose  : Runs one exponent-unpack unit over NUM_OPS packed FP operands
//             in turn and returns the per-operand results as one bundle.
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  exponent : combinational sign/exponent unpack of one packed operand.
//  Double uses bits[62:52]; single is packed in bits[63:32] and uses [62:55].
//  The exponent is returned unbiased, in 11-bit two's complement. A zero field
//  (denormal or zero) reports the minimum normal exponent.
// ----------------------------------------------------------------------------
module exponent (
   input  logic [63:0] op,
   input  logic        db,
   output logic        s,
   output logic [10:0] e,
   output logic        e_z,
   output logic        e_inf
);

   logic [10:0] exp_d;
   logic [7:0]  exp_s;
   logic [10:0] e_d;
   logic [8:0]  e_s9;
   logic        z_d;
   logic        z_s;
   logic        unused_mant;

   assign exp_d = op[62:52];
   assign exp_s = op[62:55];
   assign z_d   = (exp_d == 11'd0);
   assign z_s   = (exp_s == 8'd0);

   // Nine bits hold the single-precision range -126..+128 without overflow.
   assign e_d  = z_d ? 11'h402 : (exp_d - 11'd1023);
   assign e_s9 = z_s ? 9'h182  : ({1'b0, exp_s} - 9'd127);

   // Mantissa bits take no part in the exponent result.
   assign unused_mant = &{1'b0, op[51:0]};

   // Select the format-specific flags and exponent.
   always_comb begin
      s = op[63];
      if (db) begin
         e_z   = z_d;
         e_inf = &exp_d;
         e     = e_d;
      end else begin
         e_z   = z_s;
         e_inf = &exp_s;
         e     = {{2{e_s9[8]}}, e_s9};
      end
   end

endmodule

// ----------------------------------------------------------------------------
//  exp_unpack_sequencer : top level
// ----------------------------------------------------------------------------
module exp_unpack_sequencer #(
   parameter int NUM_OPS = 2,
   parameter int IDX_W   = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_db,
   input  logic [NUM_OPS*64-1:0]   in_ops,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_db,
   output logic [NUM_OPS-1:0]      out_s,
   output logic [NUM_OPS*11-1:0]   out_e,
   output logic [NUM_OPS-1:0]      out_e_z,
   output logic [NUM_OPS-1:0]      out_e_inf,
   output logic                    out_any_inf,
   output logic                    out_any_z,
   output logic                    busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [IDX_W-1:0]        idx;
   logic                    accept;
   logic                    last;

   logic [NUM_OPS*64-1:0]   ops_q;
   logic                    db_q;
   logic [NUM_OPS-1:0]      s_q;
   logic [NUM_OPS*11-1:0]   e_q;
   logic [NUM_OPS-1:0]      ez_q;
   logic [NUM_OPS-1:0]      einf_q;
   logic                    any_inf_q;
   logic                    any_z_q;

   logic [NUM_OPS-1:0]      s_nxt;
   logic [NUM_OPS*11-1:0]   e_nxt;
   logic [NUM_OPS-1:0]      ez_nxt;
   logic [NUM_OPS-1:0]      einf_nxt;

   logic [63:0]             cur_op;
   logic                    u_s;
   logic [10:0]             u_e;
   logic                    u_ez;
   logic                    u_einf;

   assign last = (idx == IDX_W'(NUM_OPS - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state and handshake decode; a bundle is taken only in IDLE, so the
   // cycle after a result handshake can never also accept.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = ~rst;
            if (in_valid && !rst) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (last) state_next = DONE;
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   // Pick the latched operand addressed by idx for the shared unit.
   always_comb begin
      cur_op = '0;
      for (int i = 0; i < NUM_OPS; i++) begin
         if (idx == IDX_W'(i)) cur_op = ops_q[64*i +: 64];
      end
   end

   exponent u_exponent (
      .op    (cur_op),
      .db    (db_q),
      .s     (u_s),
      .e     (u_e),
      .e_z   (u_ez),
      .e_inf (u_einf)
   );

   // Result vectors with the current unit output merged into slot idx.
   always_comb begin
      s_nxt    = s_q;
      e_nxt    = e_q;
      ez_nxt   = ez_q;
      einf_nxt = einf_q;
      for (int i = 0; i < NUM_OPS; i++) begin
         if (idx == IDX_W'(i)) begin
            s_nxt[i]          = u_s;
            e_nxt[11*i +: 11] = u_e;
            ez_nxt[i]         = u_ez;
            einf_nxt[i]       = u_einf;
         end
      end
   end

   // Operand capture, slot index and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx       <= '0;
         ops_q     <= '0;
         db_q      <= 1'b0;
         s_q       <= '0;
         e_q       <= '0;
         ez_q      <= '0;
         einf_q    <= '0;
         any_inf_q <= 1'b0;
         any_z_q   <= 1'b0;
      end else if (accept) begin
         idx       <= '0;
         ops_q     <= in_ops;
         db_q      <= in_db;
         s_q       <= '0;
         e_q       <= '0;
         ez_q      <= '0;
         einf_q    <= '0;
         any_inf_q <= 1'b0;
         any_z_q   <= 1'b0;
      end else if (state == RUN) begin
         s_q       <= s_nxt;
         e_q       <= e_nxt;
         ez_q      <= ez_nxt;
         einf_q    <= einf_nxt;
         any_inf_q <= |einf_nxt;
         any_z_q   <= |ez_nxt;
         if (!last) idx <= idx + IDX_W'(1);
      end
   end

   assign out_db      = db_q;
   assign out_s       = s_q;
   assign out_e       = e_q;
   assign out_e_z     = ez_q;
   assign out_e_inf   = einf_q;
   assign out_any_inf = any_inf_q;
   assign out_any_z   = any_z_q;

endmodule
`default_nettype wire

// File: tb/tb_exp_unpack_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exp_unpack_sequencer
//  Purpose  : Directed self-checking bench for exp_unpack_sequencer (2 ops).
//  Revision : 1.0  initial release
// ============================================================================
module tb_exp_unpack_sequencer;

   localparam int NUM_OPS = 2;
   localparam int IDX_W   = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_db;
   logic [NUM_OPS*64-1:0] in_ops;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_db;
   logic [NUM_OPS-1:0]    out_s;
   logic [NUM_OPS*11-1:0] out_e;
   logic [NUM_OPS-1:0]    out_e_z;
   logic [NUM_OPS-1:0]    out_e_inf;
   logic                  out_any_inf;
   logic                  out_any_z;
   logic                  busy;

   int n_cmp = 0;
   int n_err = 0;

   exp_unpack_sequencer #(.NUM_OPS(NUM_OPS), .IDX_W(IDX_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_db       (in_db),
      .in_ops      (in_ops),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_db      (out_db),
      .out_s       (out_s),
      .out_e       (out_e),
      .out_e_z     (out_e_z),
      .out_e_inf   (out_e_inf),
      .out_any_inf (out_any_inf),
      .out_any_z   (out_any_z),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Waits (bounded) for out_valid; an expired bound counts as a failure.
   task automatic wait_valid(input string tag);
      int k;
      k = 0;
      while (out_valid !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      chk(tag, 64'(out_valid), 64'd1);
   endtask

   initial begin
      int acc_cyc [2];
      int acc_n;
      int pulses;
      logic seen_valid;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_db     = 1'b0;
      in_ops    = '0;
      out_ready = 1'b0;
      step();
      step();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_busy",     64'(busy),     64'd0);
      rst = 1'b0;
      step();
      chk("idle_in_ready",  64'(in_ready),  64'd1);
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      chk("idle_out_e",     64'(out_e),     64'd0);

      // ---- bundle 1: 1.0 and a denormal, double ----
      in_valid = 1'b1;
      in_db    = 1'b1;
      in_ops   = {64'h0000_0000_0000_0001, 64'h3FF0_0000_0000_0000};
      step();                               // accept edge T
      in_valid = 1'b0;
      in_ops   = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      in_db    = 1'b0;
      chk("b1_busy_T1",     64'(busy),      64'd1);
      chk("b1_in_ready_T1", 64'(in_ready),  64'd0);
      chk("b1_valid_T1",    64'(out_valid), 64'd0);
      step();
      chk("b1_valid_T2",    64'(out_valid), 64'd0);
      step();
      chk("b1_valid_T3",    64'(out_valid), 64'd1);
      chk("b1_out_e",       64'(out_e),     64'({11'h402, 11'h000}));
      chk("b1_out_e_z",     64'(out_e_z),   64'(2'b10));
      chk("b1_any_z",       64'(out_any_z), 64'd1);
      chk("b1_out_s",       64'(out_s),     64'(2'b00));
      chk("b1_out_db",      64'(out_db),    64'd1);
      chk("b1_any_inf",     64'(out_any_inf), 64'd0);

      // ---- backpressure with noisy inputs ----
      for (int k = 0; k < 10; k++) begin
         in_valid = k[0];
         in_db    = ~k[0];
         in_ops   = {$urandom, $urandom, $urandom, $urandom};
         step();
         chk("bp_valid",    64'(out_valid), 64'd1);
         chk("bp_in_ready", 64'(in_ready),  64'd0);
         chk("bp_out_e",    64'(out_e),     64'({11'h402, 11'h000}));
         chk("bp_flags",    64'({out_db, out_s, out_e_z, out_e_inf, out_any_z, out_any_inf}),
                            64'({1'b1, 2'b00, 2'b10, 2'b00, 1'b1, 1'b0}));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();                               // handshake edge
      out_ready = 1'b0;
      chk("rel_valid",    64'(out_valid), 64'd0);
      chk("rel_in_ready", 64'(in_ready),  64'd1);
      chk("rel_busy",     64'(busy),      64'd0);

      // ---- infinity and sign ----
      in_valid = 1'b1;
      in_db    = 1'b1;
      in_ops   = {64'h3FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000};
      step();
      in_valid = 1'b0;
      wait_valid("inf_wait");
      chk("inf_out_e",    64'(out_e),       64'({11'h000, 11'h400}));
      chk("inf_e_inf",    64'(out_e_inf),   64'(2'b01));
      chk("inf_any_inf",  64'(out_any_inf), 64'd1);
      chk("inf_out_s",    64'(out_s),       64'(2'b01));
      chk("inf_out_e_z",  64'(out_e_z),     64'(2'b00));
      chk("inf_any_z",    64'(out_any_z),   64'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // ---- single format ----
      in_valid = 1'b1;
      in_db    = 1'b0;
      in_ops   = {64'hC040_0000_0000_0000, 64'h0000_0000_1234_5678};
      step();
      in_valid = 1'b0;
      wait_valid("sgl_wait");
      chk("sgl_out_db",   64'(out_db),    64'd0);
      chk("sgl_out_e_z",  64'(out_e_z),   64'(2'b01));
      chk("sgl_out_e",    64'(out_e),     64'({11'h001, 11'h782}));
      chk("sgl_out_s",    64'(out_s),     64'(2'b10));
      chk("sgl_e_inf",    64'(out_e_inf), 64'(2'b00));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // ---- reset in the middle of RUN ----
      in_valid = 1'b1;
      in_db    = 1'b1;
      in_ops   = {64'hFFF0_0000_0000_0000, 64'h0000_0000_0000_0000};
      step();                               // accept edge T
      in_valid = 1'b0;
      rst      = 1'b1;
      step();                               // reset edge T+1
      chk("mr_busy",     64'(busy),      64'd0);
      chk("mr_valid",    64'(out_valid), 64'd0);
      chk("mr_out_e",    64'(out_e),     64'd0);
      chk("mr_flags",    64'({out_db, out_s, out_e_z, out_e_inf, out_any_z, out_any_inf}), 64'd0);
      chk("mr_in_ready", 64'(in_ready),  64'd0);
      rst = 1'b0;
      seen_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         seen_valid = seen_valid | out_valid;
      end
      chk("mr_no_valid", 64'(seen_valid), 64'd0);
      chk("mr_idle_rdy", 64'(in_ready),   64'd1);

      // ---- back-to-back with out_ready tied high ----
      acc_n     = 0;
      pulses    = 0;
      acc_cyc   = '{0, 0};
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_db     = 1'b1;
      in_ops    = {64'h8010_0000_0000_0000, 64'h4000_0000_0000_0000};
      for (int k = 0; k < 14; k++) begin
         if (in_valid && in_ready && acc_n < 2) begin
            acc_cyc[acc_n] = k;
            acc_n++;
         end
         if (out_valid) begin
            pulses++;
            chk("b2b_out_e",   64'(out_e),   64'({11'h402, 11'h001}));
            chk("b2b_out_s",   64'(out_s),   64'(2'b10));
            chk("b2b_out_e_z", 64'(out_e_z), 64'(2'b00));
         end
         step();
         if (acc_n == 2) in_valid = 1'b0;
      end
      chk("b2b_accepts",  64'(acc_n),                   64'd2);
      chk("b2b_interval", 64'(acc_cyc[1] - acc_cyc[0]), 64'd4);
      chk("b2b_pulses",   64'(pulses),                  64'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/exp_unpack_sequencer.md
Name: exp_unpack_sequencer

Overview:
- Time-multiplexes one `exponent` unpack unit across NUM_OPS packed FP operands of one instruction. Captures the bundle with a valid/ready handshake, feeds one operand per cycle into the shared unit, registers the results, and presents them as one result bundle.
- Sits between operand fetch and the FPU unpack/normalise stage.

Parameters:
- NUM_OPS, 2, number of operands per bundle; legal range 1..4.
- IDX_W, 2, operand counter width; must satisfy 2**IDX_W >= NUM_OPS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  sequencer can accept a bundle.
- in_db  input  1  1 = double, 0 = single (single packed in bits [63:32] of each operand).
- in_ops  input  NUM_OPS*64  operand i at [64*i+63 : 64*i].
- out_valid  output  1  result bundle valid.
- out_ready  input  1  consumer accepts the result.
- out_db  output  1  captured format flag.
- out_s  output  NUM_OPS  sign per operand.
- out_e  output  NUM_OPS*11  unbiased exponent per operand, two's complement, operand i at [11*i+10 : 11*i].
- out_e_z  output  NUM_OPS  exponent field all zero.
- out_e_inf  output  NUM_OPS  exponent field all ones.
- out_any_inf  output  1  OR of out_e_inf.
- out_any_z  output  1  OR of out_e_z.
- busy  output  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- FSM states: IDLE, RUN, DONE.
- Reset state: state = IDLE, idx = 0. All result registers, out_db, out_valid and busy are 0. in_ready is 0 while rst = 1.
- IDLE:
  - in_ready = 1.
  - When in_valid & in_ready: latch in_ops and in_db, clear all result registers, set idx = 0, go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle, the latched operand[idx] drives the single shared `exponent` instance, with db = latched db.
  - At the clock edge, write s, e, e_z and e_inf into result slot idx.
  - If idx == NUM_OPS-1, go to DONE. Otherwise idx increments.
  - Exactly one `exponent` instance exists; no combinational path from in_ops to any output.
- DONE:
  - out_valid = 1. All out_* are registered and held stable until the handshake.
  - On out_valid & out_ready, go to IDLE.
  - Do not accept a new bundle in the same cycle; in_ready rises the cycle after the handshake.
- Latency and throughput:
  - If the accept occurs at edge T, out_valid is 1 from cycle T+NUM_OPS+1.
  - Minimum issue interval is NUM_OPS+2 cycles.
- Backpressure: while out_ready = 0, DONE holds indefinitely with outputs unchanged.
- Input isolation: changes on in_ops or in_db after the accept edge have no effect on the current bundle.
- Reset mid-operation: rst in any state returns to the reset state at the next edge. The in-flight bundle is discarded and out_valid drops.
- Shared-unit arithmetic, double (db = 1):
  - e_z = (bits[62:52] == 0).
  - e_inf = (bits[62:52] == 11'h7FF).
  - e = exp - 1023 for normal exponents.
  - A zero exponent field yields -1022 (11'h402).
- Shared-unit arithmetic, single (db = 0): e_z and e_inf are computed on bits[62:55]; e is the 11-bit sign-extended unit output.
- out_any_inf and out_any_z are registered and update together with the result slots.
- NUM_OPS = 1: RUN lasts exactly one cycle.

Test Plan:
- Reset, then idle: after reset, in_ready = 1, out_valid = 0, all out_e = 0. Drive NUM_OPS = 2, in_db = 1, ops {64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0001} accepted at edge T. Expect:
  - busy = 1 at T+1.
  - out_valid = 1 at T+3.
  - out_e = {11'h402, 11'h000}, out_e_z = 2'b10, out_any_z = 1, out_s = 2'b00.
- Infinity and sign: op0 = 64'hFFF0_0000_0000_0000, db = 1. Expect out_e_inf[0] = 1, out_any_inf = 1, out_s[0] = 1.
- Single format: op0 = 64'h0000_0000_xxxx_xxxx (bits[62:55] = 0), db = 0. Expect out_e_z[0] = 1, out_db = 0.
- Backpressure and isolation: hold out_ready = 0 for 10 cycles while toggling in_ops and in_valid. Expect:
  - Outputs remain bit-identical and in_ready = 0 throughout.
  - Release out_ready: out_valid falls the next cycle and in_ready rises.
- Reset mid-RUN: assert rst for one cycle at T+1. Expect at the next edge: state IDLE, busy = 0, out_valid = 0, results cleared, and no out_valid for the discarded bundle.
- Back-to-back with out_ready tied to 1: two bundles. Expect accept edges exactly NUM_OPS+2 = 4 cycles apart and one out_valid pulse per bundle.
